// File: rtl/min_hold_driver.sv
// Minimum-hold output conditioner for actuator drives.
// Holds each drive level for a guaranteed number of cycles and counts edges.
module min_hold_driver #(
    parameter int MIN_HIGH = 4,
    parameter int MIN_LOW  = 3,
    parameter int COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_level,
    input  logic               force_low,
    output logic               drive_out,
    output logic               edge_pulse,
    output logic               busy,
    output logic               pending,
    output logic [COUNT_W-1:0] edge_count
);

    localparam int MAX_HOLD = (MIN_HIGH > MIN_LOW) ? MIN_HIGH : MIN_LOW;
    localparam int CW       = $clog2(MAX_HOLD + 1);

    localparam logic [CW-1:0] HIGH_LOAD = CW'(MIN_HIGH - 1);
    localparam logic [CW-1:0] LOW_LOAD  = CW'(MIN_LOW - 1);

    typedef enum logic [1:0] {
        LOW_IDLE  = 2'b00,
        HIGH_HOLD = 2'b01,
        HIGH_IDLE = 2'b10,
        LOW_HOLD  = 2'b11
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            drive_nxt;
    logic            toggle;

    assign toggle = drive_nxt ^ drive_out;

    // Hold-state flags; only meaningful while a hold is still counting down.
    assign busy    = ((state == HIGH_HOLD) || (state == LOW_HOLD)) && (cnt != '0);
    assign pending = busy && (req_level != drive_out);

    // State, hold counter and drive/edge registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= LOW_IDLE;
            cnt        <= '0;
            drive_out  <= 1'b0;
            edge_pulse <= 1'b0;
            edge_count <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            drive_out  <= drive_nxt;
            edge_pulse <= toggle;
            edge_count <= edge_count + {{(COUNT_W-1){1'b0}}, toggle};
        end
    end

    // Next-state logic: force_low wins over req_level; holds ignore requests.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        drive_nxt = drive_out;
        case (state)
            LOW_IDLE: begin
                if (req_level && !force_low) begin
                    drive_nxt = 1'b1;
                    cnt_nxt   = HIGH_LOAD;
                    state_nxt = HIGH_HOLD;
                end
            end
            HIGH_HOLD: begin
                if (force_low || (cnt == '0 && !req_level)) begin
                    drive_nxt = 1'b0;
                    cnt_nxt   = LOW_LOAD;
                    state_nxt = LOW_HOLD;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = HIGH_IDLE;
                end
            end
            HIGH_IDLE: begin
                if (force_low || !req_level) begin
                    drive_nxt = 1'b0;
                    cnt_nxt   = LOW_LOAD;
                    state_nxt = LOW_HOLD;
                end
            end
            LOW_HOLD: begin
                // A running low hold is never restarted by force_low.
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else if (req_level && !force_low) begin
                    drive_nxt = 1'b1;
                    cnt_nxt   = HIGH_LOAD;
                    state_nxt = HIGH_HOLD;
                end else begin
                    state_nxt = LOW_IDLE;
                end
            end
            default: begin
                drive_nxt = 1'b0;
                cnt_nxt   = '0;
                state_nxt = LOW_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_min_hold_driver.sv
// Scoreboard bench for min_hold_driver (MIN_HIGH=4, MIN_LOW=3, COUNT_W=4).
// Stimulus pushes hand-computed expectations; a monitor pops after each edge.
module tb_min_hold_driver;

    logic       clk;
    logic       reset_n;
    logic       req_level;
    logic       force_low;
    logic       drive_out;
    logic       edge_pulse;
    logic       busy;
    logic       pending;
    logic [3:0] edge_count;

    typedef struct {
        string      name;
        logic       drive;
        logic       pulse;
        logic [3:0] count;
    } exp_t;

    exp_t       sb[$];
    int         checks;
    int         errors;
    logic [3:0] exp_cnt;

    logic [0:7] ch_d, ch_p, ch_b, ch_n;
    logic [0:6] w_r, w_d, w_p, w_b;

    min_hold_driver #(
        .MIN_HIGH(4),
        .MIN_LOW (3),
        .COUNT_W (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_level (req_level),
        .force_low (force_low),
        .drive_out (drive_out),
        .edge_pulse(edge_pulse),
        .busy      (busy),
        .pending   (pending),
        .edge_count(edge_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: one registered output set is due after every scheduled edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.name, ".drive"}, {3'b0, drive_out}, {3'b0, e.drive});
            chk({e.name, ".pulse"}, {3'b0, edge_pulse}, {3'b0, e.pulse});
            chk({e.name, ".count"}, edge_count, e.count);
        end
    end

    // Apply inputs for the next edge, check pre-edge busy/pending,
    // and queue the expected post-edge registered outputs.
    task automatic step(input logic r, input logic f,
                        input logic eb, input logic ep,
                        input logic d, input logic p, input string nm);
        exp_t e;
        @(negedge clk);
        req_level = r;
        force_low = f;
        #1;
        chk({nm, ".busy"}, {3'b0, busy}, {3'b0, eb});
        chk({nm, ".pending"}, {3'b0, pending}, {3'b0, ep});
        exp_cnt = exp_cnt + {3'b0, p};
        e.name  = nm;
        e.drive = d;
        e.pulse = p;
        e.count = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic mid_reset(input string nm);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk({nm, ".drive"}, {3'b0, drive_out}, 4'h0);
        chk({nm, ".pulse"}, {3'b0, edge_pulse}, 4'h0);
        chk({nm, ".count"}, edge_count, 4'h0);
        chk({nm, ".busy"}, {3'b0, busy}, 4'h0);
        chk({nm, ".pending"}, {3'b0, pending}, 4'h0);
        exp_cnt = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        exp_cnt   = '0;
        ch_d      = 8'b11111000;
        ch_p      = 8'b10000100;
        ch_b      = 8'b01110011;
        ch_n      = 8'b01010010;
        w_r       = 7'b1111000;
        w_d       = 7'b1111000;
        w_p       = 7'b1000100;
        w_b       = 7'b0111011;
        reset_n   = 1'b0;
        req_level = 1'b0;
        force_low = 1'b0;

        // Reset state before any clock edge.
        #3;
        chk("rst.drive", {3'b0, drive_out}, 4'h0);
        chk("rst.pulse", {3'b0, edge_pulse}, 4'h0);
        chk("rst.count", edge_count, 4'h0);
        chk("rst.busy", {3'b0, busy}, 4'h0);
        chk("rst.pending", {3'b0, pending}, 4'h0);
        #4;
        reset_n = 1'b1;

        // Single-cycle request stretched to MIN_HIGH, then MIN_LOW hold.
        step(1, 0, 0, 0, 1, 1, "single0");
        step(0, 0, 1, 1, 1, 0, "single1");
        step(0, 0, 1, 1, 1, 0, "single2");
        step(0, 0, 1, 1, 1, 0, "single3");
        step(0, 0, 0, 0, 0, 1, "single4");
        step(0, 0, 1, 0, 0, 0, "single5");
        step(0, 0, 1, 0, 0, 0, "single6");
        step(0, 0, 0, 0, 0, 0, "single7");

        // Chatter: request toggles every cycle for 40 cycles.
        for (int k = 0; k < 40; k++) begin
            step((k % 2) == 0, 0, ch_b[k % 8], ch_n[k % 8],
                 ch_d[k % 8], ch_p[k % 8], $sformatf("chat%0d", k));
        end
        step(0, 0, 0, 0, 0, 0, "chat_end");

        // force_low on the 2nd high cycle with request held high.
        step(1, 0, 0, 0, 1, 1, "frc0");
        step(1, 1, 1, 0, 0, 1, "frc1");
        step(1, 0, 1, 1, 0, 0, "frc2");
        step(1, 0, 1, 1, 0, 0, "frc3");
        step(1, 0, 0, 0, 1, 1, "frc4");
        // force_low during a low hold does not restart the count.
        step(0, 0, 1, 1, 1, 0, "frc5");
        step(0, 1, 1, 1, 0, 1, "frc6");
        step(0, 1, 1, 0, 0, 0, "frc7");
        step(1, 1, 1, 1, 0, 0, "frc8");
        step(1, 1, 0, 0, 0, 0, "frc9");
        // Simultaneous force_low and request in LOW_IDLE stays low.
        step(1, 1, 0, 0, 0, 0, "frc10");
        step(1, 0, 0, 0, 1, 1, "frc11");
        step(0, 0, 1, 1, 1, 0, "frc12");
        step(0, 0, 1, 1, 1, 0, "frc13");
        step(0, 0, 1, 1, 1, 0, "frc14");
        step(0, 0, 0, 0, 0, 1, "frc15");
        step(0, 0, 1, 0, 0, 0, "frc16");
        step(0, 0, 1, 0, 0, 0, "frc17");
        step(0, 0, 0, 0, 0, 0, "frc18");

        // Reset in the middle of a high hold leaves no residual hold.
        step(1, 0, 0, 0, 1, 1, "mrst0");
        mid_reset("mrst_async");
        step(1, 0, 0, 0, 1, 1, "mrst1");
        step(0, 0, 1, 1, 1, 0, "mrst2");
        step(0, 0, 1, 1, 1, 0, "mrst3");
        step(0, 0, 1, 1, 1, 0, "mrst4");
        step(0, 0, 0, 0, 0, 1, "mrst5");
        step(0, 0, 1, 0, 0, 0, "mrst6");
        step(0, 0, 1, 0, 0, 0, "mrst7");
        step(0, 0, 0, 0, 0, 0, "mrst8");

        // 16 transitions on a 4-bit counter: steps 1..15 then wraps to 0.
        mid_reset("wrap_rst");
        for (int k = 0; k < 56; k++) begin
            step(w_r[k % 7], 0, w_b[k % 7], 1'b0,
                 w_d[k % 7], w_p[k % 7], $sformatf("wrap%0d", k));
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        chk("sb_drain", 4'(sb.size()), 4'h0);
        chk("wrap_final", edge_count, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
